// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle instruction sequencer: fetches 16-bit words, walks register read,
// ALU execute and write-back phases, and resolves Z/C conditional branches.
module multi_cycle_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15,
    localparam int unsigned PC_W    = 16,
    localparam int unsigned IR_W    = 16,
    localparam int unsigned SEL_W   = 3,
    localparam int unsigned ST_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IR_W-1:0]  mem_data,
    input  logic             mem_ready,
    input  logic             C,
    input  logic             V,
    input  logic             S,
    input  logic             Z,
    output logic [PC_W-1:0]  pc,
    output logic             mem_rd,
    output logic [SEL_W-1:0] pa,
    output logic             rdr,
    output logic [SEL_W-1:0] wp,
    output logic             wrr,
    output logic [SEL_W-1:0] fsel,
    output logic             x_ld,
    output logic             y_ld,
    output logic             z_ld,
    output logic             halted,
    output logic             err,
    output logic [ST_W-1:0]  state
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned OFF_W  = 9;
    localparam int unsigned FLG_W  = 4;

    typedef enum logic [ST_W-1:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_RDA    = 4'd2,
        ST_RDB    = 4'd3,
        ST_EXEC   = 4'd4,
        ST_WB     = 4'd5,
        ST_BR     = 4'd6,
        ST_HALT   = 4'd7,
        ST_ERR    = 4'd8
    } state_e;

    localparam logic [3:0] OP_NEG  = 4'b0100;
    localparam logic [3:0] OP_MOV  = 4'b0110;
    localparam logic [3:0] OP_BZ   = 4'b1000;
    localparam logic [3:0] OP_BC   = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [FLG_W-1:0]   flags_q, flags_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               err_q, err_d;

    logic               mem_rd_q, mem_rd_d;
    logic [SEL_W-1:0]   pa_q, pa_d;
    logic               rdr_q, rdr_d;
    logic [SEL_W-1:0]   wp_q, wp_d;
    logic               wrr_q, wrr_d;
    logic [SEL_W-1:0]   fsel_q, fsel_d;
    logic               x_ld_q, x_ld_d;
    logic               y_ld_q, y_ld_d;
    logic               z_ld_q, z_ld_d;
    logic               halted_q, halted_d;

    logic [3:0]         op;
    logic [SEL_W-1:0]   rd, rs1, rs2;
    logic [OFF_W-1:0]   off;
    logic               is_bin, is_un, is_br, is_halt, br_taken;
    logic               unused_vs;

    // Instruction field decode from the latched instruction register
    always_comb begin
        op       = ir_q[15:12];
        rd       = ir_q[11:9];
        rs1      = ir_q[8:6];
        rs2      = ir_q[5:3];
        off      = ir_q[8:0];
        is_bin   = (op[3:2] == 2'b00);
        is_un    = (op == OP_NEG) || (op == OP_MOV);
        is_br    = (op == OP_BZ) || (op == OP_BC);
        is_halt  = (op == OP_HALT);
        br_taken = ((op == OP_BZ) && flags_q[0]) || ((op == OP_BC) && flags_q[3]);
    end

    // V and S are captured for completeness but no branch consumes them
    assign unused_vs = flags_q[2] ^ flags_q[1];

    // Next-state, datapath registers and registered strobe decode
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        wait_d  = '0;
        err_d   = err_q;

        unique case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (is_bin || is_un) begin
                    state_d = ST_RDA;
                end else if (is_br) begin
                    state_d = ST_BR;
                end else if (is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end
            end
            ST_RDA:  state_d = is_bin ? ST_RDB : ST_EXEC;
            ST_RDB:  state_d = ST_EXEC;
            ST_EXEC: begin
                flags_d = {C, V, S, Z};
                state_d = ST_WB;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_BR: begin
                if (br_taken) begin
                    pc_d = pc_q + {{(PC_W - OFF_W){off[OFF_W-1]}}, off};
                end
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: begin
                state_d = ST_ERR;
                err_d   = 1'b1;
            end
        endcase

        // Strobes are decoded from the upcoming state so they register glitch-free
        mem_rd_d = (state_d == ST_FETCH);
        rdr_d    = (state_d == ST_RDA) || (state_d == ST_RDB);
        x_ld_d   = (state_d == ST_RDA);
        y_ld_d   = (state_d == ST_RDB);
        z_ld_d   = (state_d == ST_EXEC);
        wrr_d    = (state_d == ST_WB);
        halted_d = (state_d == ST_HALT);
        pa_d     = (state_d == ST_RDA) ? rs1 : ((state_d == ST_RDB) ? rs2 : '0);
        wp_d     = (state_d == ST_WB) ? rd : '0;
        fsel_d   = (state_d == ST_EXEC) ? op[2:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            flags_q  <= '0;
            wait_q   <= '0;
            err_q    <= 1'b0;
            mem_rd_q <= 1'b1;
            pa_q     <= '0;
            rdr_q    <= 1'b0;
            wp_q     <= '0;
            wrr_q    <= 1'b0;
            fsel_q   <= '0;
            x_ld_q   <= 1'b0;
            y_ld_q   <= 1'b0;
            z_ld_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            flags_q  <= flags_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            mem_rd_q <= mem_rd_d;
            pa_q     <= pa_d;
            rdr_q    <= rdr_d;
            wp_q     <= wp_d;
            wrr_q    <= wrr_d;
            fsel_q   <= fsel_d;
            x_ld_q   <= x_ld_d;
            y_ld_q   <= y_ld_d;
            z_ld_q   <= z_ld_d;
            halted_q <= halted_d;
        end
    end

    assign state  = state_q;
    assign pc     = pc_q;
    assign err    = err_q;
    assign mem_rd = mem_rd_q;
    assign pa     = pa_q;
    assign rdr    = rdr_q;
    assign wp     = wp_q;
    assign wrr    = wrr_q;
    assign fsel   = fsel_q;
    assign x_ld   = x_ld_q;
    assign y_ld   = y_ld_q;
    assign z_ld   = z_ld_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: instruction-level reference model driving directed
// and random programs, comparing every cycle's outputs.
module tb_multi_cycle_ctrl;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int unsigned TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        C, V, S, Z;
    logic [15:0] pc;
    logic        mem_rd, rdr, wrr, x_ld, y_ld, z_ld, halted, err;
    logic [2:0]  pa, wp, fsel;
    logic [3:0]  state;

    multi_cycle_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .mem_data(mem_data), .mem_ready(mem_ready),
        .C(C), .V(V), .S(S), .Z(Z),
        .pc(pc), .mem_rd(mem_rd), .pa(pa), .rdr(rdr), .wp(wp), .wrr(wrr),
        .fsel(fsel), .x_ld(x_ld), .y_ld(y_ld), .z_ld(z_ld),
        .halted(halted), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] pc;
        logic        mem_rd;
        logic [2:0]  pa;
        logic        rdr;
        logic [2:0]  wp;
        logic        wrr;
        logic [2:0]  fsel;
        logic        x_ld;
        logic        y_ld;
        logic        z_ld;
        logic        halted;
        logic        err;
    } obs_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_pc;
    logic        m_z, m_c;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Per-state output table: what each phase must show
    function automatic obs_t expect_obs(input logic [3:0] st, input logic [15:0] ir, input logic [15:0] pcv);
        obs_t o;
        o    = '0;
        o.st = st;
        o.pc = pcv;
        case (st)
            4'd0: o.mem_rd = 1'b1;
            4'd2: begin o.pa = ir[8:6]; o.rdr = 1'b1; o.x_ld = 1'b1; end
            4'd3: begin o.pa = ir[5:3]; o.rdr = 1'b1; o.y_ld = 1'b1; end
            4'd4: begin o.fsel = ir[14:12]; o.z_ld = 1'b1; end
            4'd5: begin o.wp = ir[11:9]; o.wrr = 1'b1; end
            4'd7: o.halted = 1'b1;
            4'd8: o.err = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // Select fields are only meaningful in the phases that use them
    function automatic obs_t sample(input logic [3:0] est, input logic mask_rd);
        obs_t o;
        o.st = state;  o.pc = pc;     o.mem_rd = mem_rd; o.pa = pa;   o.rdr = rdr;
        o.wp = wp;     o.wrr = wrr;   o.fsel = fsel;     o.x_ld = x_ld;
        o.y_ld = y_ld; o.z_ld = z_ld; o.halted = halted; o.err = err;
        if (est != 4'd2 && est != 4'd3) o.pa = '0;
        if (est != 4'd5) o.wp = '0;
        if (mask_rd) o.mem_rd = 1'b0;
        return o;
    endfunction

    task automatic check_cycle(input string tag, input logic [3:0] st, input logic [15:0] ir, input logic mask_rd);
        obs_t e, o;
        e = expect_obs(st, ir, m_pc);
        if (mask_rd) e.mem_rd = 1'b0;
        o = sample(st, mask_rd);
        check(tag, 64'(o), 64'(e));
    endtask

    task automatic rand_inputs();
        mem_ready = 1'($urandom);
        mem_data  = 16'($urandom);
        {C, V, S, Z} = 4'($urandom);
    endtask

    function automatic logic [15:0] rand_alu();
        int s;
        logic [3:0] op;
        s  = int'($urandom_range(0, 5));
        op = (s < 4) ? 4'(s) : ((s == 4) ? 4'd4 : 4'd6);
        return {op, 12'($urandom)};
    endfunction

    function automatic logic [15:0] rand_instr();
        if ($urandom_range(0, 9) < 7) return rand_alu();
        return {3'b100, 1'($urandom), 12'($urandom)};
    endfunction

    function automatic logic [15:0] rand_illegal();
        int s;
        logic [3:0] op;
        s  = int'($urandom_range(0, 6));
        op = (s == 0) ? 4'd5 : ((s == 1) ? 4'd7 : 4'(s + 8));
        return {op, 12'($urandom)};
    endfunction

    function automatic int rand_wait();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, TIMEOUT - 1));
        return 0;
    endfunction

    task automatic do_reset();
        m_pc = RESET_PC;
        m_z  = 1'b0;
        m_c  = 1'b0;
        rst  = 1'b1;
        rand_inputs();
        step();
        check_cycle("reset", 4'd0, 16'h0, 1'b1);
        rand_inputs();
        step();
        check_cycle("reset_hold", 4'd0, 16'h0, 1'b1);
        rst = 1'b0;
        check_cycle("post_reset", 4'd0, 16'h0, 1'b0);
    endtask

    // One instruction: fetch with optional wait, then the phase path its class implies
    task automatic run_instr(input logic [15:0] instr, input int waits, input int force_fl);
        logic [3:0] op;
        logic [3:0] seq[$];
        int         o;
        op = instr[15:12];
        for (int i = 0; i <= waits; i++) begin
            check_cycle($sformatf("fetch_%h_w%0d", instr, i), 4'd0, instr, 1'b0);
            mem_ready = (i == waits);
            mem_data  = (i == waits) ? instr : 16'($urandom);
            {C, V, S, Z} = 4'($urandom);
            step();
        end
        m_pc = 16'(int'(m_pc) + 1);
        seq.push_back(4'd1);
        if (op <= 4'd3 || op == 4'd4 || op == 4'd6) begin
            seq.push_back(4'd2);
            if (op <= 4'd3) seq.push_back(4'd3);
            seq.push_back(4'd4);
            seq.push_back(4'd5);
        end else if (op == 4'd8 || op == 4'd9) begin
            seq.push_back(4'd6);
        end else begin
            for (int k = 0; k < 3; k++) seq.push_back((op == 4'hF) ? 4'd7 : 4'd8);
        end
        foreach (seq[k]) begin
            check_cycle($sformatf("%h_st%0d_c%0d", instr, seq[k], k), seq[k], instr, 1'b0);
            rand_inputs();
            if (seq[k] == 4'd4) begin
                if (force_fl >= 0) {C, V, S, Z} = 4'(force_fl);
                m_z = Z;
                m_c = C;
            end
            step();
        end
        if ((op == 4'd8 && m_z) || (op == 4'd9 && m_c)) begin
            o = int'(instr[8:0]);
            if (o >= 256) o = o - 512;
            m_pc = 16'(int'(m_pc) + o);
        end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; mem_data = '0; {C, V, S, Z} = 4'b0;

        // Basic binary/unary ops, then walk pc to 0x0010 for branch checks
        do_reset();
        run_instr(16'h0298, 0, -1);
        check("add_pc", 64'(pc), 64'(16'h0001));
        run_instr(16'h4940, 0, -1);
        for (int k = 0; k < 13; k++) run_instr(rand_alu(), rand_wait(), -1);
        run_instr(16'h0298, 0, 4'b0001);
        check("pc_0010", 64'(pc), 64'(16'h0010));
        run_instr(16'h81FE, 0, -1);
        check("bz_taken_pc", 64'(pc), 64'(16'h000F));
        run_instr(16'h0298, 0, 4'b1110);
        run_instr(16'h81FE, 0, -1);
        check("bz_not_taken_pc", 64'(pc), 64'(16'h0011));
        run_instr(16'h0298, 0, 4'b1000);
        run_instr(16'h9005, 0, -1);
        check("bc_taken_pc", 64'(pc), 64'(16'h0018));
        run_instr(16'h0298, int'(TIMEOUT) - 1, -1);

        repeat (200) run_instr(rand_instr(), rand_wait(), -1);

        // Fetch timeout, absorbing ERR, then recovery by reset
        do_reset();
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            check_cycle($sformatf("to_wait%0d", i), 4'd0, 16'h0, 1'b0);
            mem_ready = 1'b0;
            mem_data  = 16'($urandom);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check_cycle($sformatf("to_err%0d", i), 4'd8, 16'h0, 1'b0);
            rand_inputs();
            step();
        end
        do_reset();
        check("to_reset_err", 64'(err), 64'(1'b0));
        check("to_reset_pc", 64'(pc), 64'(RESET_PC));

        do_reset();
        run_instr(16'h7000, 0, -1);
        check("illegal_err", 64'(err), 64'(1'b1));
        do_reset();
        run_instr(16'hF000, 0, -1);
        check("halt_flag", 64'(halted), 64'(1'b1));
        check("halt_no_rd", 64'(mem_rd), 64'(1'b0));

        // Reset during EXEC must suppress write-back
        do_reset();
        mem_ready = 1'b1;
        mem_data  = 16'h0298;
        step();
        mem_ready = 1'b0;
        repeat (3) step();
        check("midexec_state", 64'(state), 64'(4'd4));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midexec_rst_state", 64'(state), 64'(4'd0));
        check("midexec_rst_pc", 64'(pc), 64'(RESET_PC));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midexec_wrr%0d", i), 64'(wrr), 64'(1'b0));
            step();
        end

        // pc wraps below zero via branch and above 0xFFFF via fetch
        do_reset();
        run_instr(16'h0298, 0, 4'b0001);
        run_instr(16'h81FD, 0, -1);
        check("wrap_ffff", 64'(pc), 64'(16'hFFFF));
        run_instr(rand_alu(), 0, -1);
        check("wrap_0000", 64'(pc), 64'(16'h0000));

        for (int k = 0; k < 6; k++) begin
            do_reset();
            repeat (3) run_instr(rand_instr(), rand_wait(), -1);
            run_instr((k % 2 == 1) ? {4'hF, 12'($urandom)} : rand_illegal(), rand_wait(), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 15, max FETCH wait cycles for mem_ready before error.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_data  input  16  instruction word from memory.
REQ-006 SHALL have port mem_ready  input  1  memory handshake; mem_data valid when high.
REQ-007 SHALL have port C, V, S, Z  input  1 each  ALU carry/overflow/sign/zero flags, combinational from ALU.
REQ-008 SHALL have port pc  output  16  instruction address.
REQ-009 SHALL have port mem_rd  output  1  instruction read request.
REQ-010 SHALL have port pa  output  3  register-bank read select.
REQ-011 SHALL have port rdr  output  1  register-bank read enable.
REQ-012 SHALL have port wp  output  3  register-bank write select.
REQ-013 SHALL have port wrr  output  1  register-bank write enable.
REQ-014 SHALL have port fsel  output  3  ALU function select.
REQ-015 SHALL have port x_ld, y_ld, z_ld  output  1 each  load strobes for ALU X, Y operand and Z result registers.
REQ-016 SHALL have port halted  output  1  high in HALT state.
REQ-017 SHALL have port err  output  1  sticky error (timeout or illegal opcode).
REQ-018 SHALL have port state  output  4  current FSM state code, debug.

Function
REQ-019 SHALL decode ir[15:12]=op, [11:9]=rd, [8:6]=rs1, [5:3]=rs2, [8:0]=signed branch offset.
REQ-020 SHALL treat op 0000 ADD, 0001 SUB, 0010 OR, 0011 AND as binary; 0100 NEG, 0110 MOV as unary (rs1 only); 1000 BZ, 1001 BC as branches; 1111 HALT; all other op codes illegal.
REQ-021 SHALL drive fsel=op[2:0] in EXEC for ALU ops; fsel=000 in all other states.
REQ-022 SHALL implement states FETCH=0, DECODE=1, RDA=2, RDB=3, EXEC=4, WB=5, BR=6, HALT=7, ERR=8.
REQ-023 FETCH: mem_rd=1, pc stable; on mem_ready=1 latch ir<=mem_data, pc<=pc+1 (mod 2^16), go DECODE; mem_ready in first FETCH cycle permitted (zero-wait).
REQ-024 FETCH: if mem_ready stays low for TIMEOUT consecutive cycles, go ERR, err<=1; wait counter clears on entering FETCH.
REQ-025 DECODE: ALU op -> RDA; branch -> BR; HALT -> HALT; illegal -> ERR with err<=1.
REQ-026 RDA: pa=rs1, rdr=1, x_ld=1; binary -> RDB, unary -> EXEC.
REQ-027 RDB: pa=rs2, rdr=1, y_ld=1 -> EXEC.
REQ-028 EXEC: fsel driven, z_ld=1; internal flag register <= {C,V,S,Z} sampled same edge -> WB.
REQ-029 WB: wp=rd, wrr=1 exactly one cycle -> FETCH.
REQ-030 BR: taken if (BZ and flagZ) or (BC and flagC), using registered flags; taken: pc<=pc+sext(offset) mod 2^16; -> FETCH.
REQ-031 HALT and ERR SHALL be absorbing until rst; all strobes 0 there.
REQ-032 Every strobe (mem_rd, rdr, wrr, x_ld, y_ld, z_ld) SHALL be 0 outside the states listed for it.
REQ-033 Latency with zero-wait memory: binary op 6 cycles, unary 5, branch 3, FETCH-to-FETCH.

Reset
REQ-034 rst=1 at a clock edge SHALL force state=FETCH, pc=RESET_PC, ir=0, flags=0, err=0, wait counter=0, regardless of current state or mem_ready.
REQ-035 During and immediately after reset, all strobes and halted SHALL be 0 except mem_rd, which goes 1 in the first FETCH cycle after rst deasserts.

Verification
REQ-036 Reset, mem_ready=1, mem_data=16'h0298 (ADD r1,r2,r3) -> states 0,1,2(pa=2),3(pa=3),4(fsel=000),5(wp=1,wrr=1), pc=0001.
REQ-037 NEG r4,r5 (16'h4940) -> RDB skipped, fsel=100 in EXEC, 5 cycles total.
REQ-038 After an op with Z=1, BZ offset -2 (16'h81FE) at pc=0010 -> pc becomes 000F; with Z=0 pc stays 0011.
REQ-039 mem_ready held low 15 cycles in FETCH -> ERR, err=1; then rst -> FETCH, err=0, pc=RESET_PC.
REQ-040 Illegal op 16'h7000 -> ERR; HALT 16'hF000 -> halted=1, no further mem_rd; rst asserted mid-EXEC -> no wrr pulse, restart at RESET_PC.
REQ-041 pc=16'hFFFF fetch -> pc wraps to 16'h0000.
